// File: rtl/controller_pkg.sv
// Shared definitions for the controller poll scheduler and the CPU memory map.
package controller_pkg;

    localparam int BUTTON_BITS      = 8;
    localparam int MIN_FETCH_CYCLES = 14;

    // Bit positions of each button within a controller byte.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } poll_state_t;

endpackage

// File: rtl/controller_edge_latch.sv
// Sticky "newly pressed" flags for one controller byte. A rising edge seen
// at capture wins over a same-cycle acknowledge of that bit.
module controller_edge_latch
    import controller_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [BUTTON_BITS-1:0] new_bits,
    input  logic [BUTTON_BITS-1:0] old_bits,
    input  logic [BUTTON_BITS-1:0] ack_bits,
    output logic [BUTTON_BITS-1:0] pressed
);

    logic [BUTTON_BITS-1:0] pressed_r;

    // Clear acknowledged bits every cycle; set bits on a 0->1 transition at capture.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pressed_r <= '0;
        end else if (capture) begin
            pressed_r <= (pressed_r & ~ack_bits) | (new_bits & ~old_bits);
        end else begin
            pressed_r <= pressed_r & ~ack_bits;
        end
    end

    assign pressed = pressed_r;

endmodule

// File: rtl/controller_poll_scheduler.sv
// Issues one start_fetch per frame or CPU request, waits out the fetch
// window, then snapshots the controller bytes and updates pressed flags.
module controller_poll_scheduler
    import controller_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int FETCH_CYCLES    = 16
) (
    input  logic                                   clk_in,
    input  logic                                   rst,
    input  logic                                   vsync_start,
    input  logic                                   cpu_fetch_req,
    input  logic                                   poll_enable,
    input  logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] buttons_in_LIST,
    output logic                                   start_fetch,
    output logic                                   busy,
    output logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] buttons_LIST,
    output logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] pressed_LIST,
    input  logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] ack_LIST,
    output logic                                   sample_valid,
    output logic [7:0]                             poll_count
);

    localparam int         W          = BUTTON_BITS * NUM_CONTROLLERS;
    localparam logic [7:0] CNT_LOAD   = 8'(FETCH_CYCLES - 1);

    poll_state_t state_r;
    poll_state_t next_state_s;
    logic [7:0]  cnt_r;
    logic        pending_r;
    logic        start_fetch_r;
    logic        busy_r;
    logic [W-1:0] buttons_r;
    logic        sample_valid_r;
    logic [7:0]  poll_count_r;
    logic        trig_s;
    logic        capture_s;

    assign trig_s    = (vsync_start & poll_enable) | cpu_fetch_req;
    assign capture_s = (state_r == CAPTURE);

    // Next-state decode for the poll sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (trig_s || pending_r) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START:   next_state_s = WAIT;
            WAIT: begin
                if (cnt_r == 8'd0) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            CAPTURE: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fetch-window counter: loaded in START, counts down through WAIT.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (state_r == START) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == WAIT) && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Any number of triggers while a poll is in flight collapse to one retry.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (state_r == IDLE) begin
            pending_r <= 1'b0;
        end else if (trig_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered strobes: start_fetch during START, busy from START to CAPTURE.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            start_fetch_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            start_fetch_r <= (next_state_s == START);
            busy_r        <= (next_state_s != IDLE);
        end
    end

    // Snapshot the button levels and count completed captures.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            buttons_r      <= '0;
            poll_count_r   <= 8'd0;
            sample_valid_r <= 1'b0;
        end else if (capture_s) begin
            buttons_r      <= buttons_in_LIST;
            poll_count_r   <= poll_count_r + 8'd1;
            sample_valid_r <= 1'b1;
        end else begin
            buttons_r      <= buttons_r;
            poll_count_r   <= poll_count_r;
            sample_valid_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_edge
        controller_edge_latch u_edge (
            .clk_in   (clk_in),
            .rst      (rst),
            .capture  (capture_s),
            .new_bits (buttons_in_LIST[g*BUTTON_BITS +: BUTTON_BITS]),
            .old_bits (buttons_r[g*BUTTON_BITS +: BUTTON_BITS]),
            .ack_bits (ack_LIST[g*BUTTON_BITS +: BUTTON_BITS]),
            .pressed  (pressed_LIST[g*BUTTON_BITS +: BUTTON_BITS])
        );
    end

    assign start_fetch  = start_fetch_r;
    assign busy         = busy_r;
    assign buttons_LIST = buttons_r;
    assign sample_valid = sample_valid_r;
    assign poll_count   = poll_count_r;

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// Directed bench for controller_poll_scheduler (2 controllers, 16-cycle window).
module tb_controller_poll_scheduler;

    localparam int NC = 2;
    localparam int FC = 16;
    localparam int W  = 8 * NC;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         vsync_start = 1'b0;
    logic         cpu_fetch_req = 1'b0;
    logic         poll_enable = 1'b0;
    logic [W-1:0] buttons_in_LIST = '0;
    logic [W-1:0] ack_LIST = '0;
    logic         start_fetch;
    logic         busy;
    logic [W-1:0] buttons_LIST;
    logic [W-1:0] pressed_LIST;
    logic         sample_valid;
    logic [7:0]   poll_count;

    int checks = 0;
    int errors = 0;
    int sf_count = 0;
    int sf_consec = 0;
    logic sf_prev = 1'b0;

    controller_poll_scheduler #(.NUM_CONTROLLERS(NC), .FETCH_CYCLES(FC)) dut (
        .clk_in          (clk_in),
        .rst             (rst),
        .vsync_start     (vsync_start),
        .cpu_fetch_req   (cpu_fetch_req),
        .poll_enable     (poll_enable),
        .buttons_in_LIST (buttons_in_LIST),
        .start_fetch     (start_fetch),
        .busy            (busy),
        .buttons_LIST    (buttons_LIST),
        .pressed_LIST    (pressed_LIST),
        .ack_LIST        (ack_LIST),
        .sample_valid    (sample_valid),
        .poll_count      (poll_count)
    );

    always #5 clk_in = ~clk_in;

    // Count start_fetch pulses and any back-to-back high cycles.
    always @(negedge clk_in) begin
        if (start_fetch) sf_count <= sf_count + 1;
        if (start_fetch && sf_prev) sf_consec <= sf_consec + 1;
        sf_prev <= start_fetch;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (start_fetch) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_start", {31'd0, found}, 32'd1);
    endtask

    // CPU-triggered poll; ack_cap is driven during the CAPTURE cycle.
    task automatic poll_capture(input logic [W-1:0] ack_cap);
        cpu_fetch_req = 1'b1;
        tick();
        cpu_fetch_req = 1'b0;
        wait_start();
        repeat (FC + 1) tick();
        ack_LIST = ack_cap;
        tick();
        ack_LIST = '0;
    endtask

    task automatic do_poll();
        bit seen = 1'b0;
        cpu_fetch_req = 1'b1;
        tick();
        cpu_fetch_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sample_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("poll_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int sf0;
        int bc;
        int first_sf;
        int second_sf;
        int first_sv;

        // Reset state
        repeat (3) tick();
        chk("rst_start_fetch", {31'd0, start_fetch}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_buttons", {16'd0, buttons_LIST}, 32'd0);
        chk("rst_pressed", {16'd0, pressed_LIST}, 32'd0);
        chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_poll_count", {24'd0, poll_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Single vsync poll
        poll_enable = 1'b1;
        buttons_in_LIST = 16'h00A5;
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        chk("sf_rise", {31'd0, start_fetch}, 32'd1);
        tick();
        chk("sf_one_cycle", {31'd0, start_fetch}, 32'd0);
        chk("busy_start", {31'd0, busy}, 32'd1);
        repeat (FC) tick();
        chk("busy_capture", {31'd0, busy}, 32'd1);
        chk("sv_before", {31'd0, sample_valid}, 32'd0);
        tick();
        chk("p1_buttons", {16'd0, buttons_LIST}, 32'h00A5);
        chk("p1_pressed", {16'd0, pressed_LIST}, 32'h00A5);
        chk("p1_count", {24'd0, poll_count}, 32'd1);
        chk("p1_sv", {31'd0, sample_valid}, 32'd1);
        chk("p1_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("p1_sv_pulse", {31'd0, sample_valid}, 32'd0);
        ack_LIST = 16'hFFFF;
        tick();
        ack_LIST = '0;
        chk("ack_clear", {16'd0, pressed_LIST}, 32'd0);

        // poll_enable low masks vsync; CPU request still polls
        poll_enable = 1'b0;
        sf0 = sf_count;
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        repeat (5) tick();
        chk("masked_vsync_sf", sf_count - sf0, 32'd0);
        chk("masked_vsync_busy", {31'd0, busy}, 32'd0);
        sf0 = sf_count;
        bc = 0;
        cpu_fetch_req = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            cpu_fetch_req = 1'b0;
            if (busy) bc++;
        end
        chk("cpu_busy_len", bc, FC + 2);
        chk("cpu_sf_count", sf_count - sf0, 32'd1);
        chk("held_no_reset", {16'd0, pressed_LIST}, 32'd0);
        chk("p2_count", {24'd0, poll_count}, 32'd2);

        // Simultaneous triggers, then requests during WAIT coalesce
        poll_enable = 1'b1;
        buttons_in_LIST = 16'h0000;
        sf0 = sf_count;
        first_sf = -1;
        second_sf = -1;
        first_sv = -1;
        for (int i = 0; i < 60; i++) begin
            vsync_start = (i == 0);
            cpu_fetch_req = (i == 0) || (i == 4) || (i == 6) || (i == 8);
            tick();
            if (start_fetch) begin
                if (first_sf < 0) first_sf = i;
                else if (second_sf < 0) second_sf = i;
            end
            if (sample_valid && first_sv < 0) first_sv = i;
        end
        vsync_start = 1'b0;
        cpu_fetch_req = 1'b0;
        chk("coal_sf_total", sf_count - sf0, 32'd2);
        chk("coal_first_sf", first_sf, 32'd0);
        chk("coal_first_sv", first_sv, FC + 2);
        chk("coal_second_sf", second_sf, FC + 3);
        chk("coal_count", {24'd0, poll_count}, 32'd4);

        // Edge detection and set-wins over ack
        buttons_in_LIST = 16'h0001;
        poll_capture(16'h0000);
        chk("edge_p1_pressed", {16'd0, pressed_LIST}, 32'h0001);
        buttons_in_LIST = 16'h0003;
        poll_capture(16'h0002);
        chk("edge_set_wins", {16'd0, pressed_LIST}, 32'h0003);
        chk("edge_p2_buttons", {16'd0, buttons_LIST}, 32'h0003);
        ack_LIST = 16'h0003;
        tick();
        ack_LIST = '0;
        chk("edge_ack_clear", {16'd0, pressed_LIST}, 32'h0000);
        poll_capture(16'h0000);
        chk("edge_held", {16'd0, pressed_LIST}, 32'h0000);
        chk("edge_count", {24'd0, poll_count}, 32'd7);

        // poll_count wrap
        for (int i = 0; i < 248; i++) do_poll();
        chk("count_255", {24'd0, poll_count}, 32'd255);
        do_poll();
        chk("count_wrap", {24'd0, poll_count}, 32'd0);
        buttons_in_LIST = 16'hFF03;
        poll_capture(16'h0000);
        chk("ctl1_pressed", {16'd0, pressed_LIST}, 32'hFF00);
        chk("count_after_wrap", {24'd0, poll_count}, 32'd1);

        // Reset during WAIT; trigger during reset is lost
        cpu_fetch_req = 1'b1;
        tick();
        cpu_fetch_req = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        cpu_fetch_req = 1'b1;
        tick();
        chk("mid_rst_start_fetch", {31'd0, start_fetch}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_buttons", {16'd0, buttons_LIST}, 32'd0);
        chk("mid_rst_pressed", {16'd0, pressed_LIST}, 32'd0);
        chk("mid_rst_sv", {31'd0, sample_valid}, 32'd0);
        chk("mid_rst_count", {24'd0, poll_count}, 32'd0);
        tick();
        rst = 1'b0;
        cpu_fetch_req = 1'b0;
        sf0 = sf_count;
        repeat (40) tick();
        chk("post_rst_no_sf", sf_count - sf0, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_count", {24'd0, poll_count}, 32'd0);

        chk("sf_never_consecutive", sf_consec, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
